// File: rtl/sdram_apb_arbiter.sv
// rtl/sdram_apb_arbiter.sv - two-master APB arbiter in front of the SDRAM bridge APB slave port
//
// Purpose:
//   Shares one downstream APB slave between m0 (instruction fetch) and m1
//   (load/store). The winning request is latched in IDLE. A clean
//   SETUP->ACCESS sequence is then replayed downstream, and the completion is
//   routed back to the granted master only. One transfer is in flight at a time.
//
// Ports:
//   clock, reset                 clock (posedge) and synchronous active-high reset
//   mN_psel/penable/pwrite       upstream APB control from master N (N = 0, 1)
//   mN_paddr/pwdata/pstrb/pprot  upstream APB request payload from master N
//   mN_pready/prdata/pslverr     completion, read data and error to master N
//   out_psel/penable/pwrite      downstream APB control
//   out_paddr/pwdata/pstrb/pprot latched request of the granted master
//   out_pready/prdata/pslverr    downstream completion, read data and error
//   grant_id                     master that owns the current transfer (valid while busy)
//   busy                         high in SETUP or ACCESS

module sdram_apb_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [ADDR_W-1:0]   m0_paddr,
  input  logic [DATA_W-1:0]   m0_pwdata,
  input  logic [DATA_W/8-1:0] m0_pstrb,
  input  logic [2:0]          m0_pprot,
  output logic                m0_pready,
  output logic [DATA_W-1:0]   m0_prdata,
  output logic                m0_pslverr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [ADDR_W-1:0]   m1_paddr,
  input  logic [DATA_W-1:0]   m1_pwdata,
  input  logic [DATA_W/8-1:0] m1_pstrb,
  input  logic [2:0]          m1_pprot,
  output logic                m1_pready,
  output logic [DATA_W-1:0]   m1_prdata,
  output logic                m1_pslverr,
  output logic                out_psel,
  output logic                out_penable,
  output logic                out_pwrite,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  output logic [2:0]          out_pprot,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr,
  output logic                grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  logic   rr_ptr;  // 0 favours m0, 1 favours m1 on a tie

  // Upstream penable is not needed: requests are recognised by psel alone.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  // Winner selection, only consumed while in IDLE.
  logic winner;
  always_comb begin
    winner = 1'b0;
    if (m0_psel && m1_psel) begin
      winner = (PRIO_MODE == 1) ? 1'b0 : rr_ptr;
    end else if (m1_psel) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      out_psel    <= 1'b0;
      out_penable <= 1'b0;
      out_pwrite  <= 1'b0;
      out_paddr   <= '0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
      out_pprot   <= '0;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
      rr_ptr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            state      <= SETUP;
            out_psel   <= 1'b1;
            busy       <= 1'b1;
            grant_id   <= winner;
            out_pwrite <= winner ? m1_pwrite : m0_pwrite;
            out_paddr  <= winner ? m1_paddr  : m0_paddr;
            out_pwdata <= winner ? m1_pwdata : m0_pwdata;
            out_pstrb  <= winner ? m1_pstrb  : m0_pstrb;
            out_pprot  <= winner ? m1_pprot  : m0_pprot;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          out_penable <= 1'b1;
        end
        ACCESS: begin
          if (out_pready) begin
            // Drop psel for one cycle so the slave sees a clean boundary, and
            // hand the tie-break to the master that did not just finish.
            state       <= IDLE;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            busy        <= 1'b0;
            rr_ptr      <= ~grant_id;
          end
        end
        default: begin
          state       <= IDLE;
          out_psel    <= 1'b0;
          out_penable <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Response routing. A master that withdrew psel after the grant gets nothing
  // back, and a response arriving in the reset cycle is swallowed.
  logic route0, route1, done;
  assign route0 = busy && !reset && (grant_id == 1'b0) && m0_psel;
  assign route1 = busy && !reset && (grant_id == 1'b1) && m1_psel;
  assign done   = (state == ACCESS) && out_pready;

  assign m0_pready  = route0 && done;
  assign m1_pready  = route1 && done;
  assign m0_pslverr = m0_pready && out_pslverr;
  assign m1_pslverr = m1_pready && out_pslverr;
  assign m0_prdata  = route0 ? out_prdata : '0;
  assign m1_prdata  = route1 ? out_prdata : '0;

endmodule
